// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: req/ack data-memory bus, upstream stall and M->W pipeline register.
// Optional LSU_MISALIGN_TRAP_EN: misaligned word accesses trap via misalign_fault instead of being aligned.
module mem_stage_lsu #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter bit          LOAD_SIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteM,
    input  logic                  ResultSrcM,
    input  logic                  MemWriteM,
    input  logic [ADDR_WIDTH-1:0] ALUResultM,
    input  logic [31:0]           WriteDataM,
    input  logic [4:0]            RdM,
    input  logic                  MemTypeM,
    output logic                  StallM,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [31:0]           dmem_wdata,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  RegWriteW,
    output logic                  ResultSrcW,
    output logic [ADDR_WIDTH-1:0] ALUResultW,
    output logic [31:0]           ReadDataW,
    output logic [4:0]            RdW
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_fault
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                r_state, w_next_state;
    logic                  w_acc, w_misalign, w_start, w_done;
    logic [1:0]            w_lo;
    logic                  r_regwrite, r_resultsrc, r_load, r_byte;
    logic [1:0]            r_lane;
    logic [ADDR_WIDTH-1:0] r_alu;
    logic [4:0]            r_rd;
    logic [7:0]            w_lane_byte;
    logic [31:0]           w_load_ext;

    assign w_acc = ResultSrcM | MemWriteM;
    assign w_lo  = ALUResultM[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = w_acc & ~MemTypeM & (w_lo != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif
    assign w_start = (r_state == IDLE) & w_acc & ~w_misalign;
    assign w_done  = (r_state == BUSY) & dmem_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_start)  w_next_state = BUSY;
            BUSY: if (dmem_ack) w_next_state = IDLE;
            default:            w_next_state = IDLE;
        endcase
    end

    always_comb begin
        StallM = 1'b0;
        case (r_state)
            IDLE:    StallM = w_start;
            BUSY:    StallM = ~dmem_ack;
            default: StallM = 1'b0;
        endcase
    end

    // Bus fields are launched once and held until ack; the instruction is latched alongside.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= '0;
            dmem_wdata  <= '0;
            r_regwrite  <= 1'b0;
            r_resultsrc <= 1'b0;
            r_load      <= 1'b0;
            r_byte      <= 1'b0;
            r_lane      <= '0;
            r_alu       <= '0;
            r_rd        <= '0;
        end else if (w_start) begin
            dmem_req    <= 1'b1;
            dmem_we     <= MemWriteM;
            dmem_addr   <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
            dmem_be     <= MemTypeM ? (4'b0001 << w_lo) : 4'hF;
            dmem_wdata  <= !MemWriteM ? '0 : (MemTypeM ? {4{WriteDataM[7:0]}} : WriteDataM);
            r_regwrite  <= RegWriteM & ~MemWriteM;
            r_resultsrc <= ResultSrcM;
            r_load      <= ~MemWriteM;
            r_byte      <= MemTypeM;
            r_lane      <= w_lo;
            r_alu       <= ALUResultM;
            r_rd        <= RdM;
        end else if (w_done) begin
            dmem_req    <= 1'b0;
        end
    end

    assign w_lane_byte = dmem_rdata[{r_lane, 3'b000} +: 8];
    assign w_load_ext  = !r_byte ? dmem_rdata
                       : (LOAD_SIGNED ? {{24{w_lane_byte[7]}}, w_lane_byte} : {24'h0, w_lane_byte});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
        end else if ((r_state == IDLE) && (!w_acc || w_misalign)) begin
            RegWriteW  <= RegWriteM & ~w_misalign;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= '0;
            RdW        <= RdM;
        end else if (w_done) begin
            RegWriteW  <= r_regwrite;
            ResultSrcW <= r_resultsrc;
            ALUResultW <= r_alu;
            ReadDataW  <= r_load ? w_load_ext : '0;
            RdW        <= r_rd;
        end else begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) misalign_fault <= 1'b0;
        else        misalign_fault <= (r_state == IDLE) & w_misalign;
    end
`endif

endmodule
